// File: rtl/glb_block_arbiter.sv
// Round-robin arbiter that shares one GLB read sink between length-prefixed block producers.
// The grant is held for one header word plus the number of data words that header announces.
module glb_block_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 17,
  parameter int SIZE_WIDTH = 16,
  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_PORTS-1:0]            in_valid,
  output logic [NUM_PORTS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [GW-1:0]                   grant_id,
  output logic                            busy,
  output logic                            block_done,
  output logic [15:0]                     blocks_total
);

  typedef enum logic [1:0] {IDLE, HEADER, BODY} state_t;

  state_t                  state;
  logic [GW-1:0]           rr_ptr;
  logic [GW-1:0]           pick;
  logic                    any_valid;
  logic [SIZE_WIDTH-1:0]   remaining;
  logic [SIZE_WIDTH-1:0]   hdr_size;
  logic [DATA_WIDTH-1:0]   g_data;
  logic                    g_valid;
  logic                    active;
  logic                    hs;

  function automatic logic [GW-1:0] next_port(input logic [GW-1:0] p);
    if (p == GW'(NUM_PORTS - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Scan from rr_ptr upward; iterating downward lets the closest requester win.
  always_comb begin
    int idx;
    idx       = 0;
    pick      = rr_ptr;
    any_valid = 1'b0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_PORTS;
      if (in_valid[idx]) begin
        any_valid = 1'b1;
        pick      = GW'(idx);
      end
    end
  end

  // Flush masks the passthrough so the sink never sees a handshake that is discarded.
  always_comb begin
    g_data    = in_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
    g_valid   = in_valid[grant_id];
    active    = (state != IDLE) && !flush;
    out_valid = active && g_valid;
    out_data  = out_valid ? g_data : '0;
    in_ready  = '0;
    if (active) in_ready[grant_id] = out_ready;
    hs        = out_valid && out_ready;
    hdr_size  = g_data[SIZE_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      grant_id     <= '0;
      remaining    <= '0;
      blocks_total <= '0;
      block_done   <= 1'b0;
      busy         <= 1'b0;
    end else if (flush) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      grant_id     <= '0;
      remaining    <= '0;
      blocks_total <= '0;
      block_done   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      block_done <= 1'b0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_id <= pick;
            state    <= HEADER;
            busy     <= 1'b1;
          end
        end
        HEADER: begin
          if (hs) begin
            remaining <= hdr_size;
            if (hdr_size == '0) begin
              state        <= IDLE;
              busy         <= 1'b0;
              block_done   <= 1'b1;
              blocks_total <= blocks_total + 16'd1;
              rr_ptr       <= next_port(grant_id);
            end else begin
              state <= BODY;
            end
          end
        end
        BODY: begin
          if (hs) begin
            remaining <= remaining - 1'b1;
            if (remaining == SIZE_WIDTH'(1)) begin
              state        <= IDLE;
              busy         <= 1'b0;
              block_done   <= 1'b1;
              blocks_total <= blocks_total + 16'd1;
              rr_ptr       <= next_port(grant_id);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_glb_block_arbiter.sv
// Bench for glb_block_arbiter: queue-fed producers, a rule-level cycle model, directed scenarios and a random soak.
module tb_glb_block_arbiter;
  localparam int N  = 2;
  localparam int DW = 17;
  localparam int SW = 16;
  localparam int GW = 1;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            flush;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic [GW-1:0]   grant_id;
  logic            busy;
  logic            block_done;
  logic [15:0]     blocks_total;

  glb_block_arbiter #(.NUM_PORTS(N), .DATA_WIDTH(DW), .SIZE_WIDTH(SW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .grant_id(grant_id), .busy(busy), .block_done(block_done), .blocks_total(blocks_total)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Producers: one word queue per port, popped on each accepted word.
  logic [DW-1:0] pq [N][$];
  // Model: whether a block is open, whether its header is still pending, words left, rotation start.
  bit m_act, m_hdr, m_done;
  int m_g, m_left, m_rr, m_total;
  int vprob [N];
  int rprob;
  bit force_flush, rand_flush_en, prev_busy;
  logic [DW-1:0] hs_log[$];
  int grant_log[$];
  int done_cnt;

  function automatic int pending();
    int s = m_act ? 1 : 0;
    for (int i = 0; i < N; i++) s += pq[i].size();
    return s;
  endfunction

  task automatic model_reset();
    m_act = 0; m_hdr = 0; m_done = 0; m_g = 0; m_left = 0; m_rr = 0; m_total = 0;
    for (int i = 0; i < N; i++) pq[i].delete();
  endtask

  task automatic clear_logs();
    hs_log.delete(); grant_log.delete(); done_cnt = 0;
  endtask

  task automatic push_block(input int p, input int size, input int hi);
    logic [DW-1:0] w;
    w = DW'((hi << SW) | size);
    pq[p].push_back(w);
    for (int i = 0; i < size; i++) begin
      w = DW'($urandom);
      pq[p].push_back(w);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      in_valid[i] = (pq[i].size() > 0) && ($urandom_range(0, 99) < vprob[i]);
      in_data[i*DW +: DW] = (pq[i].size() > 0) ? pq[i][0] : DW'($urandom);
    end
    out_ready = $urandom_range(0, 99) < rprob;
    flush = force_flush || (rand_flush_en && $urandom_range(0, 199) == 0);
  endtask

  task automatic check_outputs();
    logic          e_ov;
    logic [DW-1:0] e_od;
    logic [N-1:0]  e_ir;
    e_ov = 0; e_od = '0; e_ir = '0;
    if (m_act && !flush) begin
      e_ov = in_valid[m_g];
      e_od = e_ov ? in_data[m_g*DW +: DW] : '0;
      e_ir[m_g] = out_ready;
    end
    check("out_valid", out_valid, e_ov);
    check("out_data", out_data, e_od);
    check("in_ready", in_ready, e_ir);
    check("busy", busy, m_act);
    check("grant_id", grant_id, m_g);
    check("block_done", block_done, m_done);
    check("blocks_total", blocks_total, m_total);
    if (out_valid && out_ready) hs_log.push_back(out_data);
    if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
    prev_busy = busy;
    if (block_done) done_cnt++;
  endtask

  task automatic model_update();
    logic [DW-1:0] w;
    int sz;
    bit fin;
    if (flush) begin
      model_reset();
      return;
    end
    m_done = 0;
    fin = 0;
    if (!m_act) begin
      for (int k = N - 1; k >= 0; k--)
        if (in_valid[(m_rr + k) % N]) begin m_g = (m_rr + k) % N; m_act = 1; m_hdr = 1; end
    end else if (in_valid[m_g] && out_ready) begin
      w = in_data[m_g*DW +: DW];
      void'(pq[m_g].pop_front());
      if (m_hdr) begin
        sz = int'(w) % (1 << SW);
        m_hdr = 0;
        m_left = sz;
        fin = (sz == 0);
      end else begin
        m_left--;
        fin = (m_left == 0);
      end
    end
    if (fin) begin
      m_act = 0; m_done = 1; m_total = (m_total + 1) % 65536; m_rr = (m_g + 1) % N;
    end
  endtask

  task automatic step();
    @(negedge clk);
    drive();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
  endtask

  task automatic run_idle(input int maxc);
    int c = 0;
    while (pending() > 0 && c < maxc) begin step(); c++; end
    check("drain_timeout", c < maxc, 1);
    step(); step();
  endtask

  task automatic restart();
    force_flush = 1; step(); force_flush = 0;
  endtask

  logic [DW-1:0] e0[$], e1[$], ex[$];

  initial begin
    flush = 0; in_valid = '0; in_data = '0; out_ready = 0;
    for (int i = 0; i < N; i++) vprob[i] = 100;
    rprob = 100; force_flush = 0; rand_flush_en = 0; prev_busy = 0;
    model_reset(); clear_logs();
    #1 reset = 1;
    #1 check_outputs();
    #10 reset = 0;

    // Single block on port 0: header 3 then A, B, C.
    pq[0].push_back(17'h3); pq[0].push_back(17'hA); pq[0].push_back(17'hB); pq[0].push_back(17'hC);
    run_idle(50);
    ex = '{17'h3, 17'hA, 17'hB, 17'hC};
    check("t1_hs_count", hs_log.size(), 4);
    for (int i = 0; i < 4; i++) check("t1_word", (i < hs_log.size()) ? hs_log[i] : '1, ex[i]);
    check("t1_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_total", blocks_total, 1);

    // Both ports streaming size-2 blocks: strict alternation, no interleaving.
    restart(); clear_logs();
    push_block(0, 2, 0); push_block(0, 2, 1); push_block(1, 2, 1); push_block(1, 2, 0);
    e0 = pq[0]; e1 = pq[1];
    run_idle(100);
    ex = '{e0[0], e0[1], e0[2], e1[0], e1[1], e1[2], e0[3], e0[4], e0[5], e1[3], e1[4], e1[5]};
    check("t2_hs_count", hs_log.size(), 12);
    for (int i = 0; i < 12; i++) check("t2_word", (i < hs_log.size()) ? hs_log[i] : '1, ex[i]);
    check("t2_grants", grant_log.size(), 4);
    for (int i = 0; i < 4; i++) check("t2_grant", (i < grant_log.size()) ? grant_log[i] : -1, i % 2);
    check("t2_total", blocks_total, 4);

    // Header-only block on port 1, then port 0 must win the next contest.
    restart(); clear_logs();
    push_block(1, 1, 0); run_idle(50); clear_logs();
    push_block(1, 0, 1); run_idle(50);
    check("t3_hs_count", hs_log.size(), 1);
    check("t3_done_cnt", done_cnt, 1);
    clear_logs();
    push_block(0, 1, 0); push_block(1, 1, 0); run_idle(50);
    check("t3_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

    // Backpressure and source bubbles on a size-5 block.
    restart(); clear_logs();
    vprob[0] = 60; rprob = 50;
    push_block(0, 5, 1); e0 = pq[0];
    run_idle(400);
    check("t4_hs_count", hs_log.size(), 6);
    for (int i = 0; i < 6; i++) check("t4_word", (i < hs_log.size()) ? hs_log[i] : '1, e0[i]);
    vprob[0] = 100; rprob = 100;

    // Flush in BODY with two words left, then a clean block from port 1.
    restart(); clear_logs();
    push_block(1, 1, 0); run_idle(50);
    push_block(0, 4, 0);
    begin
      int c = 0;
      while (!(m_act && !m_hdr && m_left == 2) && c < 50) begin step(); c++; end
      check("t5_reach_timeout", c < 50, 1);
    end
    force_flush = 1; step(); force_flush = 0;
    step();
    check("t5_total_cleared", blocks_total, 0);
    check("t5_busy", busy, 0);
    clear_logs();
    push_block(1, 3, 0); run_idle(50);
    check("t5_done_cnt", done_cnt, 1);
    check("t5_total", blocks_total, 1);
    check("t5_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 1);

    // Asynchronous reset while the header is stalled by the sink.
    restart(); clear_logs();
    rprob = 0;
    push_block(0, 2, 0); push_block(1, 2, 0);
    begin
      int c = 0;
      while (!m_act && c < 20) begin step(); c++; end
      check("t6_grant_timeout", c < 20, 1);
    end
    @(negedge clk); drive(); out_ready = 1; #1;
    check("t6_pre_valid", out_valid, 1);
    #1 reset = 1;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_ready", in_ready, 0);
    check("t6_rst_data", out_data, 0);
    check("t6_rst_busy", busy, 0);
    in_valid = '0; reset = 0;
    model_reset();
    @(posedge clk); model_update();
    rprob = 100; clear_logs();
    push_block(0, 1, 0); push_block(1, 1, 0);
    run_idle(50);
    check("t6_grant0", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    check("t6_grant1", (grant_log.size() > 1) ? grant_log[1] : -1, 1);

    // Random soak: bubbles, backpressure, occasional flush.
    restart();
    rand_flush_en = 1; rprob = 50;
    for (int i = 0; i < N; i++) vprob[i] = $urandom_range(30, 100);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int p;
      p = $urandom_range(0, N - 1);
      if (pq[p].size() < 16 && $urandom_range(0, 3) == 0) push_block(p, $urandom_range(0, 6), $urandom_range(0, 1));
      step();
    end
    rand_flush_en = 0;
    run_idle(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
